// File: rtl/varray_run_packer_if.sv
// varray_run_packer_if
//   Element-in / run-write-out bundle for varray_run_packer.
//   Feeder side : in_valid, in_dat, in_skip, flush, out_ready (driven by master)
//   Packer side : in_ready, we, write_addr, write_addr_len, dat_w,
//                 drained, addr_exhausted (driven by slave)
interface varray_run_packer_if #(
  parameter int VIRTUAL_ELEMENT_WIDTH = 18,
  parameter int VIRTUAL_ADDR_BITS     = 16
);
  logic                             in_valid;
  logic                             in_ready;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat;
  logic                             in_skip;
  logic                             flush;
  logic                             out_ready;
  logic                             we;
  logic [VIRTUAL_ADDR_BITS-1:0]     write_addr;
  logic [4:0]                       write_addr_len;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w;
  logic                             drained;
  logic                             addr_exhausted;

  modport master (
    output in_valid, in_dat, in_skip, flush, out_ready,
    input  in_ready, we, write_addr, write_addr_len, dat_w, drained, addr_exhausted
  );

  modport slave (
    input  in_valid, in_dat, in_skip, flush, out_ready,
    output in_ready, we, write_addr, write_addr_len, dat_w, drained, addr_exhausted
  );
endinterface

// File: rtl/varray_run_packer.sv
// varray_run_packer
//   Coalesces a dense element stream (one element per virtual address from 0)
//   into runs {start, len, data} and emits one write per run. Skip elements
//   advance the address without writing. Addresses stop at 2^AW-2.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      varray_run_packer_if.slave (input handshake, flush, write strobe,
//            run fields, drained, addr_exhausted)
// Optional: define VARRAY_PACK_IDLE_FLUSH_EN to auto-flush a pending run after
//   FLUSH_TIMEOUT cycles without an accepted element.
module varray_run_packer #(
  parameter int VIRTUAL_ELEMENT_WIDTH = 18,
  parameter int VIRTUAL_ADDR_BITS     = 16,
  parameter int MAX_RUN               = 31,
  parameter int FLUSH_TIMEOUT         = 8
) (
  input logic              clk,
  input logic              reset_n,
  varray_run_packer_if.slave bus
);
  localparam int W  = VIRTUAL_ELEMENT_WIDTH;
  localparam int AW = VIRTUAL_ADDR_BITS;
  localparam logic [4:0]    MAX_LEN   = 5'(MAX_RUN);
  localparam logic [AW-1:0] LAST_ADDR = {{(AW-1){1'b1}}, 1'b0};

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [4:0]    len;
    logic [W-1:0]  dat;
    logic          vld;
  } run_t;

  run_t          pend_q, pend_d, out_q, out_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic          exh_q, exh_d;
  logic          flush_req_q, flush_req_d;

  logic slot_free, acc, extend, close_in, close_fl, we, idle_hit;

  assign slot_free = !out_q.vld | bus.out_ready;
  assign acc       = bus.in_valid & slot_free & !exh_q;
  assign we        = out_q.vld & bus.out_ready;
  assign extend    = pend_q.vld & !bus.in_skip & (bus.in_dat == pend_q.dat) &
                     (pend_q.len < MAX_LEN);
  // An accepted element that does not extend the run closes it.
  assign close_in  = acc & pend_q.vld & !extend;
  // Flush only closes on a cycle without an accept, so an element arriving
  // together with flush joins the run first.
  assign close_fl  = (flush_req_q | bus.flush | idle_hit) & pend_q.vld &
                     slot_free & !acc;

`ifdef VARRAY_PACK_IDLE_FLUSH_EN
  localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
  logic [CW-1:0] idle_q, idle_d;

  // Fires on the FLUSH_TIMEOUT-th consecutive cycle holding a run unaccepted.
  assign idle_hit = pend_q.vld & !acc & (idle_q >= CW'(FLUSH_TIMEOUT - 1));

  always_comb begin
    idle_d = idle_q;
    if (acc | we | !pend_q.vld) idle_d = '0;
    else if (!idle_hit)         idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^FLUSH_TIMEOUT;
  assign idle_hit   = 1'b0;
`endif

  always_comb begin
    pend_d      = pend_q;
    out_d       = out_q;
    cur_addr_d  = cur_addr_q;
    exh_d       = exh_q;
    if (we) out_d.vld = 1'b0;
    if (close_in | close_fl) out_d = pend_q;
    if (acc) begin
      cur_addr_d = cur_addr_q + 1'b1;
      if (cur_addr_q == LAST_ADDR) exh_d = 1'b1;
      if (bus.in_skip)  pend_d.vld = 1'b0;
      else if (extend)  pend_d.len = pend_q.len + 1'b1;
      else              pend_d = '{addr: cur_addr_q, len: 5'd1, dat: bus.in_dat, vld: 1'b1};
    end else if (close_fl) begin
      pend_d.vld = 1'b0;
    end
    // Sticky until the pending run is gone.
    flush_req_d = (flush_req_q | bus.flush | idle_hit) & pend_d.vld;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= '0;
      out_q       <= '0;
      cur_addr_q  <= '0;
      exh_q       <= 1'b0;
      flush_req_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      out_q       <= out_d;
      cur_addr_q  <= cur_addr_d;
      exh_q       <= exh_d;
      flush_req_q <= flush_req_d;
    end
  end

  assign bus.in_ready       = slot_free & !exh_q;
  assign bus.we             = we;
  assign bus.write_addr     = out_q.addr;
  assign bus.write_addr_len = out_q.len;
  assign bus.dat_w          = out_q.dat;
  assign bus.drained        = !pend_q.vld & !out_q.vld & !flush_req_q;
  assign bus.addr_exhausted = exh_q;
endmodule
